// File: rtl/id_exe_reg_if.sv
// ID->EXE pipeline bus: decode-side fields (*_in) and EXE-side registered fields (*_out).
// slave = the pipeline register, master = whoever drives decode and reads EXE side.
interface id_exe_reg_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
);
  logic          freeze;
  logic          flush;
  logic          hazard;
  logic          cond_pass;

  logic [DW-1:0] PC_in,            PC_out;
  logic [DW-1:0] Val_Rn_in,        Val_Rn_out;
  logic [DW-1:0] Val_Rm_in,        Val_Rm_out;
  logic [3:0]    EXE_CMD_in,       EXE_CMD_out;
  logic          MEM_R_EN_in,      MEM_R_EN_out;
  logic          MEM_W_EN_in,      MEM_W_EN_out;
  logic          WB_EN_in,         WB_EN_out;
  logic          S_in,             S_out;
  logic          B_in,             B_out;
  logic          imm_in,           imm_out;
  logic [RW-1:0] Dest_in,          Dest_out;
  logic [RW-1:0] src_1_in,         src_1_out;
  logic [RW-1:0] src_2_in,         src_2_out;
  logic [23:0]   Signed_imm_24_in, Signed_imm_24_out;
  logic [11:0]   Shift_operand_in, Shift_operand_out;
  logic [3:0]    SR_in,            SR_out;
  logic          valid_out;

  modport slave (
    input  freeze, flush, hazard, cond_pass,
    input  PC_in, Val_Rn_in, Val_Rm_in, EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in,
           WB_EN_in, S_in, B_in, imm_in, Dest_in, src_1_in, src_2_in,
           Signed_imm_24_in, Shift_operand_in, SR_in,
    output PC_out, Val_Rn_out, Val_Rm_out, EXE_CMD_out, MEM_R_EN_out, MEM_W_EN_out,
           WB_EN_out, S_out, B_out, imm_out, Dest_out, src_1_out, src_2_out,
           Signed_imm_24_out, Shift_operand_out, SR_out, valid_out
  );

  modport master (
    output freeze, flush, hazard, cond_pass,
    output PC_in, Val_Rn_in, Val_Rm_in, EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in,
           WB_EN_in, S_in, B_in, imm_in, Dest_in, src_1_in, src_2_in,
           Signed_imm_24_in, Shift_operand_in, SR_in,
    input  PC_out, Val_Rn_out, Val_Rm_out, EXE_CMD_out, MEM_R_EN_out, MEM_W_EN_out,
           WB_EN_out, S_out, B_out, imm_out, Dest_out, src_1_out, src_2_out,
           Signed_imm_24_out, Shift_operand_out, SR_out, valid_out
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush > freeze > bubble > load priority.
// Optional bubble/flush performance counters enabled by ID_EXE_PERF_CNT_EN.
module id_exe_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic        clk,
  input  logic        rst,
  id_exe_reg_if.slave bus
`ifdef ID_EXE_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] bubble_cnt,
  output logic [15:0] flush_cnt
`endif
);

  logic bubble;
  assign bubble = bus.hazard | ~bus.cond_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bus.flush) begin
      bus.PC_out            <= '0;
      bus.Val_Rn_out        <= '0;
      bus.Val_Rm_out        <= '0;
      bus.EXE_CMD_out       <= '0;
      bus.MEM_R_EN_out      <= 1'b0;
      bus.MEM_W_EN_out      <= 1'b0;
      bus.WB_EN_out         <= 1'b0;
      bus.S_out             <= 1'b0;
      bus.B_out             <= 1'b0;
      bus.imm_out           <= 1'b0;
      bus.Dest_out          <= '0;
      bus.src_1_out         <= '0;
      bus.src_2_out         <= '0;
      bus.Signed_imm_24_out <= '0;
      bus.Shift_operand_out <= '0;
      bus.SR_out            <= '0;
      bus.valid_out         <= 1'b0;
    end else if (!bus.freeze) begin
      // Data fields always load so a bubble still carries a traceable PC.
      bus.PC_out            <= bus.PC_in;
      bus.Val_Rn_out        <= bus.Val_Rn_in;
      bus.Val_Rm_out        <= bus.Val_Rm_in;
      bus.imm_out           <= bus.imm_in;
      bus.Dest_out          <= bus.Dest_in;
      bus.Signed_imm_24_out <= bus.Signed_imm_24_in;
      bus.Shift_operand_out <= bus.Shift_operand_in;
      bus.SR_out            <= bus.SR_in;
      // Sources are cleared on a bubble so forwarding never matches a dead entry.
      bus.src_1_out         <= bubble ? '0 : bus.src_1_in;
      bus.src_2_out         <= bubble ? '0 : bus.src_2_in;
      bus.EXE_CMD_out       <= bubble ? '0 : bus.EXE_CMD_in;
      bus.MEM_R_EN_out      <= bus.MEM_R_EN_in & ~bubble;
      bus.MEM_W_EN_out      <= bus.MEM_W_EN_in & ~bubble;
      bus.WB_EN_out         <= bus.WB_EN_in & ~bubble;
      bus.S_out             <= bus.S_in & ~bubble;
      bus.B_out             <= bus.B_in & ~bubble;
      bus.valid_out         <= ~bubble;
    end
  end

`ifdef ID_EXE_PERF_CNT_EN
  logic bubble_edge;
  assign bubble_edge = ~bus.flush & ~bus.freeze & bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (perf_clr) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_edge && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 16'd1;
      if (bus.flush && flush_cnt != '1)    flush_cnt  <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: vector table, directed corner sequences and a randomized
// run against a priority-rule model; perf counters checked when ID_EXE_PERF_CNT_EN is set.
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  cmd;
    logic        mr, mw, wb, s, b, imm;
    logic [3:0]  dest, s1, s2;
    logic [23:0] simm;
    logic [11:0] shop;
    logic [3:0]  sr;
    logic        valid;
  } fields_t;

  typedef struct {
    logic        flush, freeze, hazard, cond;
    logic [31:0] pc;
    logic        wb;
    logic [3:0]  s1;
    logic [31:0] e_pc;
    logic        e_wb;
    logic [3:0]  e_s1;
    logic        e_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_exe_reg_if #(.DW(32), .RW(4)) bus ();

`ifdef ID_EXE_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] bubble_cnt, flush_cnt;
  id_exe_reg #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .perf_clr(perf_clr), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );
`else
  id_exe_reg #(.DW(32), .RW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic fl, input logic fr, input logic hz, input logic cp);
    bus.flush = fl; bus.freeze = fr; bus.hazard = hz; bus.cond_pass = cp;
  endtask

  task automatic set_in(input fields_t f);
    bus.PC_in = f.pc;       bus.Val_Rn_in = f.rn;   bus.Val_Rm_in = f.rm;
    bus.EXE_CMD_in = f.cmd; bus.MEM_R_EN_in = f.mr; bus.MEM_W_EN_in = f.mw;
    bus.WB_EN_in = f.wb;    bus.S_in = f.s;         bus.B_in = f.b;
    bus.imm_in = f.imm;     bus.Dest_in = f.dest;   bus.src_1_in = f.s1;
    bus.src_2_in = f.s2;    bus.Signed_imm_24_in = f.simm;
    bus.Shift_operand_in = f.shop; bus.SR_in = f.sr;
  endtask

  function automatic fields_t get_out();
    fields_t f;
    f.pc = bus.PC_out;       f.rn = bus.Val_Rn_out;   f.rm = bus.Val_Rm_out;
    f.cmd = bus.EXE_CMD_out; f.mr = bus.MEM_R_EN_out; f.mw = bus.MEM_W_EN_out;
    f.wb = bus.WB_EN_out;    f.s = bus.S_out;         f.b = bus.B_out;
    f.imm = bus.imm_out;     f.dest = bus.Dest_out;   f.s1 = bus.src_1_out;
    f.s2 = bus.src_2_out;    f.simm = bus.Signed_imm_24_out;
    f.shop = bus.Shift_operand_out; f.sr = bus.SR_out; f.valid = bus.valid_out;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.pc = $urandom; f.rn = $urandom; f.rm = $urandom;
    f.cmd = 4'($urandom); f.mr = 1'($urandom); f.mw = 1'($urandom);
    f.wb = 1'($urandom);  f.s = 1'($urandom);  f.b = 1'($urandom);
    f.imm = 1'($urandom); f.dest = 4'($urandom); f.s1 = 4'($urandom);
    f.s2 = 4'($urandom);  f.simm = 24'($urandom); f.shop = 12'($urandom);
    f.sr = 4'($urandom);  f.valid = 1'b0;
    return f;
  endfunction

  // What EXE should see after one edge, straight from the priority rules.
  function automatic fields_t model(input fields_t cur, input fields_t in,
                                    input logic fl, input logic fr, input logic hz, input logic cp);
    fields_t n;
    if (fl) return '0;
    if (fr) return cur;
    n = in;
    if (hz || !cp) begin
      n.cmd = 4'd0; n.mr = 1'b0; n.mw = 1'b0; n.wb = 1'b0; n.s = 1'b0; n.b = 1'b0;
      n.s1 = 4'd0;  n.s2 = 4'd0; n.valid = 1'b0;
    end else begin
      n.valid = 1'b1;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t    vecs[10];
  fields_t f, e, cur;

  initial begin
    // pc, wb, s1 vary per row; other inputs held at 0
    vecs[0] = '{1'b0,1'b0,1'b0,1'b1, 32'h4,         1'b1, 4'h5, 32'h4,         1'b1, 4'h5, 1'b1};
    vecs[1] = '{1'b0,1'b1,1'b0,1'b1, 32'h8,         1'b0, 4'h6, 32'h4,         1'b1, 4'h5, 1'b1};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b1, 32'hC,         1'b1, 4'h7, 32'hC,         1'b0, 4'h0, 1'b0};
    vecs[3] = '{1'b0,1'b0,1'b0,1'b0, 32'h10,        1'b1, 4'h3, 32'h10,        1'b0, 4'h0, 1'b0};
    vecs[4] = '{1'b1,1'b1,1'b1,1'b1, 32'h14,        1'b1, 4'h2, 32'h0,         1'b0, 4'h0, 1'b0};
    vecs[5] = '{1'b0,1'b1,1'b1,1'b1, 32'h18,        1'b1, 4'h1, 32'h0,         1'b0, 4'h0, 1'b0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b1, 32'h1C,        1'b1, 4'h9, 32'h1C,        1'b1, 4'h9, 1'b1};
    vecs[7] = '{1'b1,1'b0,1'b0,1'b1, 32'h20,        1'b1, 4'h9, 32'h0,         1'b0, 4'h0, 1'b0};
    vecs[8] = '{1'b0,1'b0,1'b1,1'b0, 32'h24,        1'b1, 4'hF, 32'h24,        1'b0, 4'h0, 1'b0};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b1, 32'hFFFFFFFC,  1'b1, 4'hF, 32'hFFFFFFFC,  1'b1, 4'hF, 1'b1};

    // Asynchronous reset: load all-ones, then drop rst mid-cycle
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    set_in('1);
    tick();
    chk("load_all_ones_valid", 256'(bus.valid_out), 256'(1));
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_immediate", 256'(get_out()), 256'(0));
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("reset_held_over_edge", 256'(get_out()), 256'(0));
    rst = 1'b1;
    f = '0; f.pc = 32'h8; f.cmd = 4'h1; f.wb = 1'b1;
    set_in(f);
    tick();
    e = f; e.valid = 1'b1;
    chk("first_load_after_reset", 256'(get_out()), 256'(e));

    // Vector table
    set_in('0);
    foreach (vecs[i]) begin
      set_ctrl(vecs[i].flush, vecs[i].freeze, vecs[i].hazard, vecs[i].cond);
      bus.PC_in = vecs[i].pc; bus.WB_EN_in = vecs[i].wb; bus.src_1_in = vecs[i].s1;
      tick();
      chk($sformatf("vec%0d_pc", i),    256'(bus.PC_out),    256'(vecs[i].e_pc));
      chk($sformatf("vec%0d_wb", i),    256'(bus.WB_EN_out), 256'(vecs[i].e_wb));
      chk($sformatf("vec%0d_src1", i),  256'(bus.src_1_out), 256'(vecs[i].e_s1));
      chk($sformatf("vec%0d_valid", i), 256'(bus.valid_out), 256'(vecs[i].e_v));
    end

    // Cond fail with memory write
    set_in('0);
    f = '0; f.pc = 32'h10; f.wb = 1'b1; f.mw = 1'b1; f.s1 = 4'd3;
    set_in(f); set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = '0; e.pc = 32'h10;
    chk("cond_fail_bubble", 256'(get_out()), 256'(e));

    // Freeze holds for 3 edges, then releases
    f = '0; f.rn = 32'hDEAD; set_in(f); set_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    f.rn = 32'hBEEF; set_in(f); bus.freeze = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("freeze_hold%0d", k), 256'(bus.Val_Rn_out), 256'(32'hDEAD));
    end
    bus.freeze = 1'b0;
    tick();
    chk("freeze_release", 256'(bus.Val_Rn_out), 256'(32'hBEEF));
    chk("freeze_release_valid", 256'(bus.valid_out), 256'(1));

    // Flush + freeze + hazard together
    f = rand_fields(); f.mr = 1'b1; set_in(f); set_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_freeze_hazard", 256'(get_out()), 256'(0));

    // Hazard on a branch
    f = '0; f.b = 1'b1; f.simm = 24'h000004; set_in(f); set_ctrl(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    e = '0; e.simm = 24'h000004;
    chk("hazard_branch", 256'(get_out()), 256'(e));

    // Randomized run against the model, with occasional mid-stream resets
    cur = get_out();
    for (int unsigned n = 0; n < 400; n++) begin
      logic fl, fr, hz, cp, do_rst;
      fl = ($urandom_range(7) == 0);
      fr = ($urandom_range(4) == 0);
      hz = ($urandom_range(4) == 0);
      cp = ($urandom_range(5) != 0);
      do_rst = ($urandom_range(49) == 0);
      f = rand_fields();
      set_in(f); set_ctrl(fl, fr, hz, cp);
      if (do_rst) begin
        rst = 1'b0;
        #1;
        chk("rand_async_reset", 256'(get_out()), 256'(0));
      end
      tick();
      cur = do_rst ? fields_t'('0) : model(cur, f, fl, fr, hz, cp);
      rst = 1'b1;
      chk($sformatf("rand%0d", n), 256'(get_out()), 256'(cur));
      if (!bus.valid_out)
        chk("bubble_invariant",
            256'({bus.MEM_R_EN_out, bus.MEM_W_EN_out, bus.WB_EN_out, bus.B_out, bus.S_out}), 256'(0));
    end

`ifdef ID_EXE_PERF_CNT_EN
    set_in('0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clear_start", 256'({bubble_cnt, flush_cnt}), 256'(0));
    set_ctrl(1'b0, 1'b0, 1'b1, 1'b1);
    for (int unsigned k = 0; k < 5; k++) tick();
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 2; k++) tick();
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("perf_bubble_cnt", 256'(bubble_cnt), 256'(5));
    chk("perf_flush_cnt",  256'(flush_cnt),  256'(2));
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 65530; k++) tick();
    chk("perf_bubble_full", 256'(bubble_cnt), 256'(16'hFFFF));
    tick();
    chk("perf_bubble_sat", 256'(bubble_cnt), 256'(16'hFFFF));
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_zero", 256'({bubble_cnt, flush_cnt}), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
